// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU processing core: opcodes, FSM states,
// flag bit positions, CRC polynomials and message lengths.
package mtm_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CRC4 = 3'd1,
        S_EXEC = 3'd2,
        S_CRC3 = 3'd3,
        S_SEND = 3'd4,
        S_GAP  = 3'd5
    } state_e;

    // Positions inside the 4-bit flag word {carry, overflow, zero, negative}
    localparam int FLAG_CARRY = 3;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_NEG   = 0;

    localparam logic [3:0] CRC4_POLY = 4'b0011;
    localparam logic [2:0] CRC3_POLY = 3'b011;

    localparam int CRC4_BITS = 68;
    localparam int CRC3_BITS = 37;

    typedef struct packed {
        logic data;
        logic crc;
        logic op;
    } err_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mtm_alu_crc_serial.sv
// Bit-serial CRC engine, MSB-first, zero initial value; clear wins over shift.
module mtm_alu_crc_serial #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);

    logic [WIDTH-1:0] crc_q, crc_d;
    logic             fb;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        fb    = crc_q[WIDTH-1] ^ din;
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (shift) begin
            crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/mtm_alu_core.sv
// ALU processing stage: checks request CRC4/opcode, executes, computes CRC3
// over the response and launches it to the serializer with a post-launch gap.
module mtm_alu_core
    import mtm_alu_pkg::*;
#(
    parameter int GAP_CYCLES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [31:0] rx_A,
    input  logic [31:0] rx_B,
    input  logic [2:0]  rx_op,
    input  logic [3:0]  rx_crc,
    input  logic        rx_err_data,
    output logic        tx_data,
    output logic        error_occured,
    output logic [31:0] data_C,
    output logic [3:0]  data_flag,
    output logic [2:0]  data_crc,
    output logic [5:0]  error_flag,
    output logic        busy
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W = (GAP_W > 7) ? GAP_W : 7;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d, b_q, b_d, c_q, c_d, out_c_q, out_c_d;
    logic [2:0]         op_q, op_d, out_crc_q, out_crc_d;
    logic [3:0]         rxcrc_q, rxcrc_d, flag_q, flag_d, out_flag_q, out_flag_d;
    logic [5:0]         err_flag_q, err_flag_d;
    logic               tx_q, tx_d, eo_q, eo_d;

    logic               capture, exec_ok, enter_send;
    err_t               err;
    logic [3:0]         crc4;
    logic [2:0]         crc3;
    logic               crc4_shift, crc4_din, crc3_shift, crc3_din;
    logic [32:0]        sum;
    logic [31:0]        c_new;
    logic [3:0]         flags_new;
    logic [67:0]        msg4;
    logic [37:0]        msg3_pad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        exec_ok    = 1'b0;
        enter_send = 1'b0;
        err        = '0;
        case (state_q)
            S_IDLE: if (rx_valid) begin
                capture = 1'b1;
                if (rx_err_data) begin
                    err.data   = 1'b1;
                    enter_send = 1'b1;
                    state_d    = S_SEND;
                end else begin
                    state_d = S_CRC4;
                    cnt_d   = CNT_W'(CRC4_BITS - 1);
                end
            end
            S_CRC4: begin
                if (cnt_q == '0) state_d = S_EXEC;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_EXEC: begin
                if (crc4 != rxcrc_q) begin
                    err.crc    = 1'b1;
                    enter_send = 1'b1;
                    state_d    = S_SEND;
                end else if (!op_is_valid(op_q)) begin
                    err.op     = 1'b1;
                    enter_send = 1'b1;
                    state_d    = S_SEND;
                end else begin
                    exec_ok = 1'b1;
                    state_d = S_CRC3;
                    cnt_d   = CNT_W'(CRC3_BITS - 1);
                end
            end
            S_CRC3: begin
                if (cnt_q == '0) begin
                    enter_send = 1'b1;
                    state_d    = S_SEND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SEND: begin
                state_d = S_GAP;
                cnt_d   = CNT_W'(GAP_CYCLES - 1);
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // 33-bit add/subtract: bit 32 is the carry, or the borrow for SUB.
    always_comb begin
        sum   = (op_q == OP_SUB) ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
        c_new = sum[31:0];
        flags_new = '0;
        flags_new[FLAG_CARRY] = sum[32];
        if (op_q == OP_SUB) flags_new[FLAG_OVF] = (a_q[31] != b_q[31]) && (c_new[31] != a_q[31]);
        else                flags_new[FLAG_OVF] = (a_q[31] == b_q[31]) && (c_new[31] != a_q[31]);
        if (op_q == OP_AND || op_q == OP_OR) begin
            c_new = (op_q == OP_AND) ? (a_q & b_q) : (a_q | b_q);
            flags_new[FLAG_CARRY] = 1'b0;
            flags_new[FLAG_OVF]   = 1'b0;
        end
        flags_new[FLAG_ZERO] = (c_new == '0);
        flags_new[FLAG_NEG]  = c_new[31];
    end

    // CRC3 takes its first bit (C[31]) during EXEC so its last shift lands one
    // cycle before SEND; msg3_pad[cnt] then walks the remaining 36 bits.
    always_comb begin
        busy       = (state_q != S_IDLE);
        msg4       = {b_q, a_q, 1'b1, op_q};
        msg3_pad   = {c_q, 1'b0, flag_q, 1'b0};
        crc4_shift = (state_q == S_CRC4);
        crc4_din   = msg4[cnt_q[6:0]];
        crc3_shift = (state_q == S_EXEC) || ((state_q == S_CRC3) && (cnt_q != '0));
        crc3_din   = (state_q == S_EXEC) ? c_new[31] : msg3_pad[cnt_q[5:0]];
    end

    mtm_alu_crc_serial #(.WIDTH(4), .POLY(CRC4_POLY)) u_crc4 (
        .clk(clk), .rst(rst), .clear(capture), .shift(crc4_shift), .din(crc4_din), .crc(crc4)
    );

    mtm_alu_crc_serial #(.WIDTH(3), .POLY(CRC3_POLY)) u_crc3 (
        .clk(clk), .rst(rst), .clear(capture), .shift(crc3_shift), .din(crc3_din), .crc(crc3)
    );

    always_comb begin
        a_d        = capture ? rx_A   : a_q;
        b_d        = capture ? rx_B   : b_q;
        op_d       = capture ? rx_op  : op_q;
        rxcrc_d    = capture ? rx_crc : rxcrc_q;
        c_d        = exec_ok ? c_new     : c_q;
        flag_d     = exec_ok ? flags_new : flag_q;
        tx_d       = enter_send;
        eo_d       = enter_send && (err != '0);
        err_flag_d = enter_send ? {err, err} : err_flag_q;
        out_c_d    = out_c_q;
        out_flag_d = out_flag_q;
        out_crc_d  = out_crc_q;
        // Error frames keep the last good result on the data outputs.
        if (enter_send && (err == '0)) begin
            out_c_d    = c_q;
            out_flag_d = flag_q;
            out_crc_d  = crc3;
        end
    end

    // NOTE: datapath registers are reset too, so outputs read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0; b_q <= '0; op_q <= '0; rxcrc_q <= '0;
            c_q <= '0; flag_q <= '0;
            out_c_q <= '0; out_flag_q <= '0; out_crc_q <= '0; err_flag_q <= '0;
            tx_q <= 1'b0; eo_q <= 1'b0;
        end else begin
            a_q <= a_d; b_q <= b_d; op_q <= op_d; rxcrc_q <= rxcrc_d;
            c_q <= c_d; flag_q <= flag_d;
            out_c_q <= out_c_d; out_flag_q <= out_flag_d; out_crc_q <= out_crc_d;
            err_flag_q <= err_flag_d;
            tx_q <= tx_d; eo_q <= eo_d;
        end
    end

    assign tx_data       = tx_q;
    assign error_occured = eo_q;
    assign data_C        = out_c_q;
    assign data_flag     = out_flag_q;
    assign data_crc      = out_crc_q;
    assign error_flag    = err_flag_q;

endmodule

// File: tb/tb_mtm_alu_core.sv
// Self-checking bench for mtm_alu_core: directed frames, corner arithmetic,
// randomized requests against a behavioural model, gap and reset behaviour.
module tb_mtm_alu_core;

    localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD_ = 3'b100, SUB_ = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_A = '0, rx_B = '0;
    logic [2:0]  rx_op = '0;
    logic [3:0]  rx_crc = '0;
    logic        rx_err_data = 1'b0;
    logic        tx_data, error_occured, busy;
    logic [31:0] data_C;
    logic [3:0]  data_flag;
    logic [2:0]  data_crc;
    logic [5:0]  error_flag;

    mtm_alu_core #(.GAP_CYCLES(60)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_A(rx_A), .rx_B(rx_B),
        .rx_op(rx_op), .rx_crc(rx_crc), .rx_err_data(rx_err_data),
        .tx_data(tx_data), .error_occured(error_occured), .data_C(data_C),
        .data_flag(data_flag), .data_crc(data_crc), .error_flag(error_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the held data outputs (last good frame)
    logic [31:0] m_c = '0;
    logic [3:0]  m_flag = '0;
    logic [2:0]  m_crc3 = '0;

    // Captured response of the last request
    int          r_lat;
    logic        r_eo;
    logic [31:0] r_c;
    logic [3:0]  r_flag;
    logic [2:0]  r_crc;
    logic [5:0]  r_ef;

    function automatic logic [3:0] ref_crc4(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [67:0] m;
        logic [3:0]  c;
        m = {b, a, 1'b1, op};
        c = '0;
        for (int i = 67; i >= 0; i--) c = {c[2:0], 1'b0} ^ ((c[3] ^ m[i]) ? 4'b0011 : 4'b0000);
        return c;
    endfunction

    function automatic logic [2:0] ref_crc3(input logic [31:0] cv, input logic [3:0] f);
        logic [36:0] m;
        logic [2:0]  c;
        m = {cv, 1'b0, f};
        c = '0;
        for (int i = 36; i >= 0; i--) c = {c[1:0], 1'b0} ^ ((c[2] ^ m[i]) ? 3'b011 : 3'b000);
        return c;
    endfunction

    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                    output logic [31:0] cv, output logic [3:0] f);
        longint sa, sb, s;
        logic   carry, ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        carry = 1'b0;
        ovf = 1'b0;
        case (op)
            AND_: cv = a & b;
            OR_:  cv = a | b;
            ADD_: begin
                cv = a + b;
                carry = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                s = sa + sb;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            default: begin
                cv = a - b;
                carry = (a < b);
                s = sa - sb;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
        endcase
        f = {carry, ovf, (cv == 32'd0), cv[31]};
    endfunction

    // Predicts latency and error fields; updates the held-output model on good frames.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [3:0] crc, input logic errd,
                         output int lat, output logic eo, output logic [5:0] ef);
        logic [31:0] cv;
        logic [3:0]  f;
        if (errd) begin
            lat = 1; eo = 1'b1; ef = 6'b100100;
        end else if (crc != ref_crc4(a, b, op)) begin
            lat = 70; eo = 1'b1; ef = 6'b010010;
        end else if (!(op inside {AND_, OR_, ADD_, SUB_})) begin
            lat = 70; eo = 1'b1; ef = 6'b001001;
        end else begin
            lat = 107; eo = 1'b0; ef = 6'b000000;
            ref_alu(a, b, op, cv, f);
            m_c = cv; m_flag = f; m_crc3 = ref_crc3(cv, f);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns in the pulse cycle.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [3:0] crc, input logic errd);
        rx_A = a; rx_B = b; rx_op = op; rx_crc = crc; rx_err_data = errd; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_err_data = 1'b0;
        rx_A = $urandom; rx_B = $urandom; rx_op = 3'($urandom); rx_crc = 4'($urandom);
        r_lat = -1;
        for (int k = 1; k <= 300; k++) begin
            if (tx_data === 1'b1) begin
                r_lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        r_eo = error_occured; r_c = data_C; r_flag = data_flag; r_crc = data_crc; r_ef = error_flag;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400 && busy !== 1'b0; k++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle busy=%b want 0 after 400 cycles", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx_data, error_occured, busy, data_C, data_flag, data_crc, error_flag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got tx=%b eo=%b busy=%b C=%h flag=%b crc=%b ef=%b want all 0",
                     tx_data, error_occured, busy, data_C, data_flag, data_crc, error_flag);
        end
        rst = 1'b0;
        m_c = '0; m_flag = '0; m_crc3 = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed_valid();
        int lat; logic eo; logic [5:0] ef;
        model(32'd0, 32'd0, AND_, 4'b1011, 1'b0, lat, eo, ef);
        do_req(32'd0, 32'd0, AND_, 4'b1011, 1'b0);
        checks++;
        if (r_lat !== 107) begin errors++; $display("FAIL valid_latency got %0d want 107", r_lat); end
        checks++;
        if ({r_eo, r_c, r_flag, r_crc, r_ef} !== {1'b0, 32'd0, 4'b0010, 3'b110, 6'b0}) begin
            errors++;
            $display("FAIL valid_frame got eo=%b C=%h flag=%b crc=%b ef=%b want eo=0 C=0 flag=0010 crc=110 ef=0",
                     r_eo, r_c, r_flag, r_crc, r_ef);
        end
        @(posedge clk); #1;
        checks++;
        if ({tx_data, busy, data_C, data_flag, data_crc} !== {1'b0, 1'b1, 32'd0, 4'b0010, 3'b110}) begin
            errors++;
            $display("FAIL pulse_width got tx=%b busy=%b C=%h flag=%b crc=%b want tx=0 busy=1 held frame",
                     tx_data, busy, data_C, data_flag, data_crc);
        end
        wait_idle();
    endtask

    task automatic test_errors();
        int lat; logic eo; logic [5:0] ef;
        logic [3:0] good;
        // Bad CRC on the same message
        model(32'd0, 32'd0, AND_, 4'b0000, 1'b0, lat, eo, ef);
        do_req(32'd0, 32'd0, AND_, 4'b0000, 1'b0);
        checks++;
        if (r_lat !== 70 || r_eo !== 1'b1 || r_ef !== 6'b010010) begin
            errors++;
            $display("FAIL crc_error got lat=%0d eo=%b ef=%b want lat=70 eo=1 ef=010010", r_lat, r_eo, r_ef);
        end
        checks++;
        if ({r_c, r_flag, r_crc} !== {m_c, m_flag, m_crc3}) begin
            errors++;
            $display("FAIL crc_error_hold got C=%h flag=%b crc=%b want C=%h flag=%b crc=%b",
                     r_c, r_flag, r_crc, m_c, m_flag, m_crc3);
        end
        @(posedge clk); #1;
        checks++;
        if (error_occured !== 1'b0 || tx_data !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_width got eo=%b tx=%b want 0 0", error_occured, tx_data);
        end
        wait_idle();
        // Illegal opcode with a correct CRC
        good = ref_crc4(32'd0, 32'd0, 3'b010);
        model(32'd0, 32'd0, 3'b010, good, 1'b0, lat, eo, ef);
        do_req(32'd0, 32'd0, 3'b010, good, 1'b0);
        checks++;
        if (r_lat !== 70 || r_eo !== 1'b1 || r_ef !== 6'b001001) begin
            errors++;
            $display("FAIL op_error got lat=%0d eo=%b ef=%b want lat=70 eo=1 ef=001001", r_lat, r_eo, r_ef);
        end
        wait_idle();
        // Data error together with a bad CRC: data error wins
        model(32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 4'b0000, 1'b1, lat, eo, ef);
        do_req(32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 4'b0000, 1'b1);
        checks++;
        if (r_lat !== 1 || r_eo !== 1'b1 || r_ef !== 6'b100100) begin
            errors++;
            $display("FAIL data_error got lat=%0d eo=%b ef=%b want lat=1 eo=1 ef=100100", r_lat, r_eo, r_ef);
        end
        checks++;
        if ({r_c, r_flag, r_crc} !== {m_c, m_flag, m_crc3}) begin
            errors++;
            $display("FAIL data_error_hold got C=%h flag=%b crc=%b want C=%h flag=%b crc=%b",
                     r_c, r_flag, r_crc, m_c, m_flag, m_crc3);
        end
        wait_idle();
    endtask

    task automatic test_corner();
        logic [31:0] ta [5] = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hF0F0_F0F0};
        logic [31:0] tb [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0F0F_0F0F};
        logic [2:0]  to [5] = '{ADD_, SUB_, SUB_, ADD_, AND_};
        logic [31:0] tc [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        logic [3:0]  tf [5] = '{4'b0101, 4'b1001, 4'b0100, 4'b1010, 4'b0010};
        int lat; logic eo; logic [5:0] ef;
        for (int i = 0; i < 5; i++) begin
            model(ta[i], tb[i], to[i], ref_crc4(ta[i], tb[i], to[i]), 1'b0, lat, eo, ef);
            do_req(ta[i], tb[i], to[i], ref_crc4(ta[i], tb[i], to[i]), 1'b0);
            checks++;
            if (r_lat !== 107 || r_eo !== 1'b0 || r_c !== tc[i] || r_flag !== tf[i] || r_crc !== ref_crc3(tc[i], tf[i])) begin
                errors++;
                $display("FAIL corner_%0d got lat=%0d eo=%b C=%h flag=%b crc=%b want lat=107 eo=0 C=%h flag=%b crc=%b",
                         i, r_lat, r_eo, r_c, r_flag, r_crc, tc[i], tf[i], ref_crc3(tc[i], tf[i]));
            end
            wait_idle();
        end
    endtask

    task automatic test_random();
        logic [31:0] special [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [3:0]  crc;
        logic        errd;
        int lat; logic eo; logic [5:0] ef;
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            op = ($urandom_range(0, 4) == 0) ? 3'($urandom) : ((3'($urandom_range(0, 1)) << 2) | 3'($urandom_range(0, 1)));
            crc = ($urandom_range(0, 6) == 0) ? 4'($urandom) : ref_crc4(a, b, op);
            errd = ($urandom_range(0, 9) == 0);
            model(a, b, op, crc, errd, lat, eo, ef);
            do_req(a, b, op, crc, errd);
            checks++;
            if (r_lat !== lat || r_eo !== eo || r_ef !== ef || r_c !== m_c || r_flag !== m_flag || r_crc !== m_crc3) begin
                errors++;
                $display("FAIL random_%0d A=%h B=%h op=%b got lat=%0d eo=%b ef=%b C=%h flag=%b crc=%b want lat=%0d eo=%b ef=%b C=%h flag=%b crc=%b",
                         i, a, b, op, r_lat, r_eo, r_ef, r_c, r_flag, r_crc, lat, eo, ef, m_c, m_flag, m_crc3);
            end
            wait_idle();
        end
    endtask

    task automatic test_gap();
        int lat; logic eo; logic [5:0] ef;
        int extra;
        logic b167, b168;
        extra = 0; b167 = 1'b0; b168 = 1'b1;
        model(32'd5, 32'd7, ADD_, ref_crc4(32'd5, 32'd7, ADD_), 1'b0, lat, eo, ef);
        do_req(32'd5, 32'd7, ADD_, ref_crc4(32'd5, 32'd7, ADD_), 1'b0);
        for (int k = 108; k <= 175; k++) begin
            @(posedge clk); #1;
            if (tx_data === 1'b1) extra++;
            if (k == 167) b167 = busy;
            if (k == 168) b168 = busy;
            rx_valid = (k == 120);
            rx_err_data = (k == 120);
        end
        rx_valid = 1'b0; rx_err_data = 1'b0;
        checks++;
        if (b167 !== 1'b1 || b168 !== 1'b0) begin
            errors++;
            $display("FAIL gap_length got busy@167=%b busy@168=%b want 1 0", b167, b168);
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL gap_ignore got %0d extra pulses want 0", extra);
        end
        wait_idle();
    endtask

    task automatic test_ignore_and_reset();
        int lat; logic eo; logic [5:0] ef;
        int pulses, first;
        logic [3:0] good;
        pulses = 0; first = -1;
        good = ref_crc4(32'hDEAD_BEEF, 32'h0000_1111, OR_);
        model(32'hDEAD_BEEF, 32'h0000_1111, OR_, good, 1'b0, lat, eo, ef);
        rx_A = 32'hDEAD_BEEF; rx_B = 32'h0000_1111; rx_op = OR_; rx_crc = good; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        for (int k = 1; k <= 250; k++) begin
            if (tx_data === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
            rx_valid = (k == 50);
            rx_err_data = (k == 50);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0; rx_err_data = 1'b0;
        checks++;
        if (pulses !== 1 || first !== 107 || data_C !== m_c) begin
            errors++;
            $display("FAIL ignore_busy got pulses=%0d first=%0d C=%h want pulses=1 first=107 C=%h", pulses, first, data_C, m_c);
        end
        wait_idle();
        // Third request aborted by reset at cycle 80
        rx_A = 32'd3; rx_B = 32'd4; rx_op = ADD_; rx_crc = ref_crc4(32'd3, 32'd4, ADD_); rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        m_c = '0; m_flag = '0; m_crc3 = '0;
        checks++;
        if (busy !== 1'b0 || tx_data !== 1'b0 || data_C !== 32'd0 || error_flag !== 6'd0) begin
            errors++;
            $display("FAIL abort_reset got busy=%b tx=%b C=%h ef=%b want 0 0 0 0", busy, tx_data, data_C, error_flag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 200; k++) begin
            if (tx_data === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_pulse got %0d pulses want 0", pulses);
        end
        // Recovery after reset
        model(32'd3, 32'd4, SUB_, ref_crc4(32'd3, 32'd4, SUB_), 1'b0, lat, eo, ef);
        do_req(32'd3, 32'd4, SUB_, ref_crc4(32'd3, 32'd4, SUB_), 1'b0);
        checks++;
        if (r_lat !== 107 || r_c !== m_c || r_flag !== m_flag || r_crc !== m_crc3) begin
            errors++;
            $display("FAIL after_reset got lat=%0d C=%h flag=%b crc=%b want lat=107 C=%h flag=%b crc=%b",
                     r_lat, r_c, r_flag, r_crc, m_c, m_flag, m_crc3);
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_directed_valid();
        test_errors();
        test_corner();
        test_random();
        test_gap();
        test_ignore_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtm_alu_core.md
Name: mtm_alu_core

Overview:
- Processing stage between the ALU deserializer and the serializer.
- Takes one decoded request (A, B, op, CRC4, frame-error flag), checks CRC4 and the opcode, and executes AND/OR/ADD/SUB.
- Computes the 3-bit CRC over the result and flags, then presents the response with a one-cycle launch pulse.
- Both CRCs are computed bit-serially. A post-launch gap keeps the serializer from receiving a pulse while it is still transmitting.

Parameters:
- GAP_CYCLES, 60, cycles spent in GAP after each launch before a new request is accepted (must be at least the longest serializer frame).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active high
- rx_valid  in  1  one-cycle strobe: request fields valid
- rx_A  in  32  operand A
- rx_B  in  32  operand B
- rx_op  in  3  opcode
- rx_crc  in  4  received CRC4
- rx_err_data  in  1  frame/format error detected upstream
- tx_data  out  1  one-cycle launch pulse to serializer
- error_occured  out  1  one-cycle pulse, coincident with tx_data, selects error frame
- data_C  out  32  result
- data_flag  out  4  {carry, overflow, zero, negative}
- data_crc  out  3  CRC3 of {data_C, 1'b0, data_flag}
- error_flag  out  6  {err_data, err_crc, err_op, err_data, err_crc, err_op}
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, state IDLE, counters 0.
- Clock and reset: one clock (clk); asynchronous active-high reset (rst).
- States are IDLE, CRC4, EXEC, CRC3, SEND, GAP.
- IDLE:
  - On rx_valid, capture all rx_* fields.
  - If rx_err_data=1, go to SEND with err_data=1.
  - Otherwise go to CRC4 with bit counter = 67.
- CRC4:
  - Engine runs over the 68-bit message {B, A, 1'b1, op}, MSB first, one bit per cycle.
  - Initial value 0. fb = crc[3]^din; crc = {crc[2:0],0} ^ (fb ? 4'b0011 : 0). Polynomial x^4+x+1.
  - After 68 bits go to EXEC.
- EXEC (1 cycle):
  - If CRC4 != captured rx_crc, set err_crc and go to SEND.
  - Else if op is not in {000 AND, 001 OR, 100 ADD, 101 SUB}, set err_op and go to SEND.
  - Otherwise compute C with a 33-bit add/subtract and go to CRC3.
- Flags:
  - carry = bit 32 of A+B or A-B; for SUB this is the borrow, i.e. 1 when A<B unsigned.
  - overflow = signed overflow; always 0 for AND/OR.
  - zero = (C==0); negative = C[31].
- CRC3:
  - 37-bit message {C, 1'b0, flags}, MSB first, initial 0, poly 3'b011 (x^3+x+1).
  - 37 cycles, then go to SEND.
- SEND (1 cycle):
  - Assert tx_data=1.
  - error_occured=1 iff any error; error_flag built from the one-hot error.
  - Error priority is data > crc > op; exactly one error bit is set.
  - data_C, data_flag, data_crc, error_flag are registered and stay stable from this cycle until the next SEND.
  - In an error frame, data_C, data_flag and data_crc hold their previous values.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- rx_valid outside IDLE is ignored: the request is dropped and no state changes.
- Latency from the rx_valid cycle (= cycle 0) to tx_data:
  - valid request: 107 cycles;
  - CRC or opcode error: 70 cycles;
  - rx_err_data: 1 cycle.
- Reset mid-operation: immediate return to IDLE; no tx_data is produced for the aborted request.

Decomposition:
- Package mtm_alu_pkg:
  - opcode constants OP_AND/OP_OR/OP_ADD/OP_SUB;
  - core state encoding;
  - flag bit indices;
  - CRC polynomials 4'b0011 and 3'b011.
- Sub-module mtm_alu_crc_serial:
  - parameter WIDTH (3 or 4) and POLY;
  - ports clear, shift, din, crc;
  - instantiated twice, or once and time-shared.

Test Plan:
- A=0, B=0, op=000, crc=4'b1011 -> tx_data at cycle 107; error_occured=0; data_C=0; data_flag=4'b0010; data_crc=3'b110.
- Same request with crc=4'b0000 -> tx_data and error_occured at cycle 70; error_flag=6'b010010.
- A=0, B=0, op=010 with the correct CRC4 for that message (golden model) -> pulse at cycle 70; error_flag=6'b001001.
- rx_err_data=1 together with a bad CRC -> pulse at cycle 1; error_flag=6'b100100 (data error wins).
- A=32'h7FFFFFFF, B=1, ADD -> C=32'h80000000; flags {0,1,0,1}. A=0, B=1, SUB -> C=32'hFFFFFFFF; carry=1, negative=1. data_crc must match the golden model in both cases.
- Second rx_valid at cycle 50, then rst pulsed at cycle 80 of a third request -> only one tx_data (first request); busy=0 right after reset; no pulse for the aborted request.
